// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, sampling constants and baud divider helper for the UART blocks
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    localparam logic [3:0] SAMPLE_LO   = 4'd7;
    localparam logic [3:0] SAMPLE_MID  = 4'd8;
    localparam logic [3:0] SAMPLE_HI   = 4'd9;
    localparam logic [3:0] SAMPLE_LAST = 4'd15;
    localparam int         DATA_BITS   = 8;

    function automatic int uart_div(input int clk_hz, input int baud, input int ovs);
        return clk_hz / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-clk oversample tick every DIV clocks
module uart_baud_tick #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick  = cnt_q == CW'(DIV - 1);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // wrap the divider at DIV-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 UART receiver, 16x oversampled with mid-bit majority vote; even parity via UART_RX_PARITY_EN
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int OVS    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int         DIV      = uart_div(CLK_HZ, BAUD, OVS);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam state_e     AFTER_DATA = PARITY;
`else
    localparam state_e     AFTER_DATA = STOP;
`endif

    logic       tick;
    logic       sync1_q, sync2_q;
    state_e     state_q;
    logic [3:0] cnt_q;
    logic [2:0] bit_q;
    logic [1:0] smp_q;
    logic [7:0] shift_q;
    logic       arm_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, rx_full_q, overrun_q, frame_err_q;
    logic       line, vote, at_hi, at_last, par_ok;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign line    = sync2_q;
    assign vote    = (smp_q[0] & smp_q[1]) | (line & (smp_q[0] | smp_q[1]));
    assign at_hi   = cnt_q == SAMPLE_HI;
    assign at_last = cnt_q == SAMPLE_LAST;

`ifdef UART_RX_PARITY_EN
    logic par_q, parity_err_q;
    assign par_ok     = ~^{shift_q, par_q};
    assign parity_err = parity_err_q;

    // parity bit capture and sticky parity error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (rx_ack) parity_err_q <= 1'b0;
            if (tick && state_q == PARITY && at_hi) par_q <= vote;
            if (tick && state_q == STOP && at_hi && !par_ok) parity_err_q <= 1'b1;
        end
    end
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    // two-flop synchroniser on the asynchronous serial line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
        end
    end

    // frame FSM and status flags; flag sets come after the ack clear so a coincident set wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            smp_q       <= '0;
            shift_q     <= '0;
            arm_q       <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_full_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (rx_ack) begin
                rx_full_q   <= 1'b0;
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
            if (tick) begin
                if (state_q == IDLE) begin
                    cnt_q <= '0;
                    if (line) arm_q <= 1'b1;
                    else if (arm_q) state_q <= START;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SAMPLE_LO)  smp_q[0] <= line;
                    if (cnt_q == SAMPLE_MID) smp_q[1] <= line;
                    case (state_q)
                        START: begin
                            if (at_hi && vote) state_q <= IDLE;
                            else if (at_last) begin
                                state_q <= DATA;
                                bit_q   <= '0;
                            end
                        end
                        DATA: begin
                            if (at_hi) shift_q <= {vote, shift_q[7:1]};
                            if (at_last) begin
                                bit_q <= bit_q + 1'b1;
                                if (bit_q == LAST_BIT) state_q <= AFTER_DATA;
                            end
                        end
                        STOP: begin
                            if (at_hi) begin
                                state_q <= IDLE;
                                if (!vote) begin
                                    frame_err_q <= 1'b1;
                                    arm_q       <= 1'b0;
                                end else if (par_ok) begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                    rx_full_q  <= 1'b1;
                                    if (rx_full_q && !rx_ack) overrun_q <= 1'b1;
                                end
                            end
                        end
`ifdef UART_RX_PARITY_EN
                        PARITY: if (at_last) state_q <= STOP;
`endif
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_full   = rx_full_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = state_q != IDLE;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: table-driven frames with a byte scoreboard plus hand sequences for glitch, ack race and reset
module tb_uart_rx_oversample;

    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_full, overrun, frame_err, parity_err, rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_vcyc = 0;
    int last_start = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       ack;
        logic [7:0] e_data;
        logic       e_full;
        logic       e_ovr;
        logic       e_ferr;
    } vec_t;

    vec_t tbl[5];

    uart_rx_oversample #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_full    (rx_full),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rx_valid) begin
            last_vcyc = cyc;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected rx_valid: got data %0h expected no byte", rx_data);
            end else begin
                chk("scoreboard byte", rx_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic align();
        while (cyc % 10 != 0) clks(1);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        clks(1);
        rx_ack = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        clks(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        align();
        last_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) uart_rx = 1'b1;
`endif
        drive_bit(stop);
        if (!stop) drive_bit(1'b1);
        uart_rx = 1'b1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] d, input logic full, input logic ovr, input logic ferr);
        chk({tag, " rx_data"}, rx_data, d);
        chk({tag, " rx_full"}, {7'd0, rx_full}, {7'd0, full});
        chk({tag, " overrun"}, {7'd0, overrun}, {7'd0, ovr});
        chk({tag, " frame_err"}, {7'd0, frame_err}, {7'd0, ferr});
        chk({tag, " parity_err"}, {7'd0, parity_err}, 8'd0);
        chk({tag, " rx_busy"}, {7'd0, rx_busy}, 8'd0);
    endtask

    initial begin
        int delta, target;
        tbl[0] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'h0F, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};

        clks(3);
        chk("reset rx_valid", {7'd0, rx_valid}, 8'd0);
        reset = 1'b0;
        clks(2);
        chk_state("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].ack) pulse_ack();
            if (tbl[i].stop) sb_q.push_back(tbl[i].d);
            send_frame(tbl[i].d, tbl[i].stop, ^tbl[i].d);
            chk_state($sformatf("row%0d", i), tbl[i].e_data, tbl[i].e_full, tbl[i].e_ovr, tbl[i].e_ferr);
        end

        delta = last_vcyc - last_start;
        align();
        target = cyc + delta - 1;
        sb_q.push_back(8'h81);
        fork
            send_frame(8'h81, 1'b1, 1'b0);
            begin
                while (cyc < target) clks(1);
                rx_ack = 1'b1;
                clks(1);
                rx_ack = 1'b0;
            end
        join
        chk_state("ack race", 8'h81, 1'b1, 1'b0, 1'b0);

        uart_rx = 1'b0;
        clks(20);
        chk("glitch busy", {7'd0, rx_busy}, 8'd1);
        clks(20);
        uart_rx = 1'b1;
        clks(120);
        chk_state("glitch", 8'h81, 1'b1, 1'b0, 1'b0);

        align();
        uart_rx = 1'b0;
        clks(BIT);
        uart_rx = 1'b1;
        clks(3 * BIT + BIT / 2);
        chk("mid frame busy", {7'd0, rx_busy}, 8'd1);
        reset = 1'b1;
        clks(3);
        reset = 1'b0;
        clks(1);
        chk_state("mid reset", 8'h00, 1'b0, 1'b0, 1'b0);
        clks(6 * BIT);
        sb_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        chk_state("after reset", 8'h12, 1'b1, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
        pulse_ack();
        send_frame(8'h07, 1'b1, 1'b0);
        chk("parity parity_err", {7'd0, parity_err}, 8'd1);
        chk("parity rx_full", {7'd0, rx_full}, 8'd0);
        chk("parity rx_data", rx_data, 8'h12);
`endif

        clks(10);
        chk("scoreboard drained", 8'(sb_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
